// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two ALU requesters, the
// arbiter and the result consumer.
//   req0/req1, op0/op1, a0/a1, b0/b1 : requester side (master drives)
//   gnt0/gnt1                        : one-cycle grant pulses (slave drives)
//   rsp_valid/rsp_ready              : result handshake
//   rsp_id, rsp_data                 : owner and value of the current result
//   busy, op_count                   : status
interface alu_arbiter_if #(
   parameter int unsigned WIDTH    = 15,
   parameter int unsigned OP_WIDTH = 3
);
   logic                req0;
   logic                req1;
   logic [OP_WIDTH-1:0] op0;
   logic [OP_WIDTH-1:0] op1;
   logic [WIDTH-1:0]    a0;
   logic [WIDTH-1:0]    a1;
   logic [WIDTH-1:0]    b0;
   logic [WIDTH-1:0]    b1;
   logic                gnt0;
   logic                gnt1;
   logic                rsp_valid;
   logic                rsp_ready;
   logic                rsp_id;
   logic [WIDTH:0]      rsp_data;
   logic                busy;
   logic [7:0]          op_count;

   modport slave (
      input  req0, req1, op0, op1, a0, a1, b0, b1, rsp_ready,
      output gnt0, gnt1, rsp_valid, rsp_id, rsp_data, busy, op_count
   );

   modport master (
      output req0, req1, op0, op1, a0, a1, b0, b1, rsp_ready,
      input  gnt0, gnt1, rsp_valid, rsp_id, rsp_data, busy, op_count
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one ALU between two
// requesters. A grant is issued only in IDLE, the winner's operands are
// captured, the result is computed in EXEC and presented in RESP until the
// consumer accepts it.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_arbiter_if slave port (requests, grants, response, status)
module alu_arbiter #(
   parameter int unsigned WIDTH    = 15,
   parameter int unsigned OP_WIDTH = 3
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);

   localparam int unsigned RES_W = WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e              state_q;
   logic                ptr_q;        // port that wins when both request
   logic [OP_WIDTH-1:0] op_q;
   logic [WIDTH-1:0]    a_q;
   logic [WIDTH-1:0]    b_q;
   logic                id_q;
   logic                rsp_valid_q;
   logic [RES_W-1:0]    rsp_data_q;
   logic [7:0]          op_count_q;
   logic [7:0]          op_count_d;

   logic                win_c;
   logic                gnt_any_c;
   logic [RES_W-1:0]    a_x_c;
   logic [RES_W-1:0]    b_x_c;
   logic [RES_W-1:0]    alu_c;

   // Arbitration: a lone requester wins, otherwise the pointer decides.
   // Reset gates the grant so nothing is issued while rst_n is low.
   always_comb begin
      gnt_any_c = rst_n && (state_q == IDLE) && (bus.req0 || bus.req1);
      if (bus.req0 && bus.req1) begin
         win_c = ptr_q;
      end else begin
         win_c = bus.req1;
      end
   end

   assign bus.gnt0 = gnt_any_c && !win_c;
   assign bus.gnt1 = gnt_any_c &&  win_c;

   // ALU on zero-extended captured operands; unknown opcodes yield 0.
   always_comb begin
      a_x_c = {1'b0, a_q};
      b_x_c = {1'b0, b_q};
      case (op_q)
         OP_WIDTH'(1): alu_c = a_x_c + b_x_c;
         OP_WIDTH'(2): alu_c = a_x_c - b_x_c;
         OP_WIDTH'(3): alu_c = a_x_c & b_x_c;
         OP_WIDTH'(4): alu_c = a_x_c | b_x_c;
         OP_WIDTH'(5): alu_c = a_x_c ^ b_x_c;
         default:      alu_c = '0;
      endcase
   end

   // Saturating completion count.
   assign op_count_d = (op_count_q == 8'hFF) ? op_count_q : op_count_q + 8'd1;

   // Control FSM and all registered state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         op_count_q  <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_any_c) begin
                  op_q    <= win_c ? bus.op1 : bus.op0;
                  a_q     <= win_c ? bus.a1  : bus.a0;
                  b_q     <= win_c ? bus.b1  : bus.b0;
                  id_q    <= win_c;
                  ptr_q   <= ~win_c;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               rsp_data_q  <= alu_c;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  op_count_q  <= op_count_d;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
   localparam int unsigned W  = 15;
   localparam int unsigned OW = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(W), .OP_WIDTH(OW)) bus ();
   alu_arbiter #(.WIDTH(W), .OP_WIDTH(OW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic          req [2];
   logic [OW-1:0] opv [2];
   logic [W-1:0]  av  [2];
   logic [W-1:0]  bv  [2];
   logic          rdy;

   assign bus.req0 = req[0];
   assign bus.req1 = req[1];
   assign bus.op0  = opv[0];
   assign bus.op1  = opv[1];
   assign bus.a0   = av[0];
   assign bus.a1   = av[1];
   assign bus.b0   = bv[0];
   assign bus.b1   = bv[1];
   assign bus.rsp_ready = rdy;

   int checks = 0;
   int errors = 0;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference ALU straight from the opcode table, result modulo 2^(W+1).
   function automatic longint ref_alu(input int op, input longint a, input longint b);
      longint m;
      m = (longint'(1) << (W + 1)) - 1;
      case (op)
         1:       return (a + b) & m;
         2:       return (a - b) & m;
         3:       return a & b;
         4:       return a | b;
         5:       return a ^ b;
         default: return 0;
      endcase
   endfunction

   // Scoreboard / reference model state (written only by the monitor).
   typedef struct {
      int     id;
      longint data;
   } exp_t;
   exp_t   sb [$];
   bit     inflight = 0;
   bit     seen     = 0;
   int     gcyc     = 0;
   int     acc_cyc  = 0;
   int     mcnt     = 0;
   int     prio     = 0;
   int     cyc      = 0;
   int     glog_p [$];
   int     glog_c [$];
   longint last_data = 0;
   int     last_id   = 0;

   // Monitor: predicts grants from the round-robin rule, pushes the expected
   // result on each grant and pops/compares whenever a result is presented.
   always @(negedge clk) begin
      int w;
      bit has, eg0, eg1;
      cyc++;
      if (!rst_n) begin
         chk(!bus.gnt0 && !bus.gnt1, "gnt_in_reset", {bus.gnt0, bus.gnt1}, 0);
         sb.delete();
         inflight = 0;
         seen     = 0;
         mcnt     = 0;
         prio     = 0;
      end else begin
         chk(bus.op_count == mcnt, "op_count", bus.op_count, mcnt);
         chk(bus.busy == inflight, "busy", bus.busy, inflight);
         has = bus.req0 || bus.req1;
         w   = (bus.req0 && bus.req1) ? prio : (bus.req1 ? 1 : 0);
         eg0 = !inflight && has && (w == 0);
         eg1 = !inflight && has && (w == 1);
         chk(bus.gnt0 == eg0, "gnt0", bus.gnt0, eg0);
         chk(bus.gnt1 == eg1, "gnt1", bus.gnt1, eg1);
         if (bus.rsp_valid) begin
            if (sb.size() == 0 || cyc < gcyc + 2) begin
               chk(0, "rsp_unexpected", bus.rsp_valid, 0);
            end else begin
               chk(bus.rsp_id == sb[0].id, "rsp_id", bus.rsp_id, sb[0].id);
               chk(bus.rsp_data == sb[0].data, "rsp_data", bus.rsp_data, sb[0].data);
               if (!seen) begin
                  chk(cyc == gcyc + 2, "rsp_latency", cyc - gcyc, 2);
                  seen = 1;
               end
               if (rdy) begin
                  last_data = sb[0].data;
                  last_id   = sb[0].id;
                  void'(sb.pop_front());
                  inflight = 0;
                  acc_cyc  = cyc;
                  mcnt     = (mcnt == 255) ? 255 : mcnt + 1;
               end
            end
         end else if (inflight && cyc >= gcyc + 2) begin
            chk(0, "rsp_missing", bus.rsp_valid, 1);
         end
         if (eg0 || eg1) begin
            sb.push_back('{w, ref_alu(int'(opv[w]), longint'(av[w]), longint'(bv[w]))});
            inflight = 1;
            seen     = 0;
            gcyc     = cyc;
            prio     = 1 - w;
            glog_p.push_back(w);
            glog_c.push_back(cyc);
         end
      end
   end

   // Raise req on port p and hold it until granted; hold>0 drops it unserved
   // after that many cycles. Called and returns at posedge+1.
   task automatic drive(input int p, input int op, input longint a, input longint b, input int hold);
      bit got;
      int lim;
      got = 0;
      lim = (hold == 0) ? 300 : hold;
      req[p] = 1'b1;
      opv[p] = OW'(op);
      av[p]  = W'(a);
      bv[p]  = W'(b);
      for (int i = 0; i < lim && !got; i++) begin
         @(negedge clk);
         got = (p == 0) ? bus.gnt0 : bus.gnt1;
      end
      if (!got && hold == 0) chk(0, "gnt_timeout", p, p);
      @(posedge clk);
      #1;
      req[p] = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         #1;
         ok = !inflight && (sb.size() == 0);
      end
      if (!ok) chk(0, "idle_timeout", inflight, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sweep_op  [6];
      int sweep_exp [6];
      bit done;
      req[0] = 0; req[1] = 0;
      opv[0] = '0; opv[1] = '0;
      av[0] = '0; av[1] = '0; bv[0] = '0; bv[1] = '0;
      rdy = 1'b1;
      @(posedge clk);
      #1;
      do_reset();
      chk(bus.rsp_valid == 0, "rst_rsp_valid", bus.rsp_valid, 0);
      chk(bus.rsp_data == 0, "rst_rsp_data", bus.rsp_data, 0);
      chk(bus.rsp_id == 0, "rst_rsp_id", bus.rsp_id, 0);
      chk(bus.busy == 0, "rst_busy", bus.busy, 0);
      chk(bus.op_count == 0, "rst_op_count", bus.op_count, 0);

      // Contention from reset: both requests held, expect 0,1,0,1 at 3-cycle spacing.
      rst_n = 1'b0;
      glog_p.delete();
      glog_c.delete();
      fork
         begin drive(0, 1, 10, 20, 0); drive(0, 3, 12, 10, 0); end
         begin drive(1, 2, 50, 7, 0);  drive(1, 5, 9, 3, 0);   end
         begin repeat (3) @(posedge clk); #1; rst_n = 1'b1; end
      join
      wait_idle();
      chk(glog_p.size() == 4, "cont_count", glog_p.size(), 4);
      if (glog_p.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk(glog_p[i] == (i % 2), "cont_order", glog_p[i], i % 2);
            if (i > 0) chk(glog_c[i] - glog_c[i-1] == 3, "cont_spacing", glog_c[i] - glog_c[i-1], 3);
         end
      end

      // Single add with carry into the top bit.
      do_reset();
      drive(0, 1, 'h7FFF, 'h0001, 0);
      wait_idle();
      chk(last_data == 'h8000, "add_data", last_data, 'h8000);
      chk(last_id == 0, "add_id", last_id, 0);
      chk(bus.op_count == 1, "add_count", bus.op_count, 1);

      // Subtraction wrap.
      drive(1, 2, 0, 1, 0);
      wait_idle();
      chk(last_data == 'hFFFF, "sub_data", last_data, 'hFFFF);
      chk(last_id == 1, "sub_id", last_id, 1);

      // Backpressure: result held 5 extra cycles while req0 waits.
      rdy = 1'b0;
      drive(0, 4, 'h1234, 'h00F0, 0);
      fork
         drive(0, 5, 'h0F0F, 'h00FF, 0);
         begin
            repeat (6) @(posedge clk);
            #1;
            chk(bus.rsp_valid == 1, "bp_valid", bus.rsp_valid, 1);
            chk(bus.busy == 1, "bp_busy", bus.busy, 1);
            chk(bus.gnt0 == 0, "bp_no_gnt", bus.gnt0, 0);
            rdy = 1'b1;
         end
      join
      chk(glog_c[$] - acc_cyc == 1, "bp_next_gnt", glog_c[$] - acc_cyc, 1);
      wait_idle();

      // Reset during EXEC discards the operation.
      do_reset();
      drive(0, 1, 3, 4, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk(bus.rsp_valid == 0, "midrst_valid", bus.rsp_valid, 0);
      chk(bus.busy == 0, "midrst_busy", bus.busy, 0);
      chk(bus.op_count == 0, "midrst_count", bus.op_count, 0);
      @(posedge clk);
      #1;

      // Opcode sweep.
      sweep_op  = '{0, 6, 7, 3, 4, 5};
      sweep_exp = '{0, 0, 0, 'h1111, 'h7777, 'h6666};
      for (int i = 0; i < 6; i++) begin
         if (i < 3) drive(i % 2, sweep_op[i], $urandom, $urandom, 0);
         else       drive(i % 2, sweep_op[i], 'h5555, 'h3333, 0);
         wait_idle();
         chk(last_data == sweep_exp[i], "sweep_data", last_data, sweep_exp[i]);
      end

      // Random traffic with random backpressure and occasional abandoned requests.
      done = 0;
      fork
         begin
            fork
               for (int i = 0; i < 150; i++) begin
                  repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                  drive(0, $urandom_range(0, 7), $urandom, $urandom, ($urandom_range(0, 15) == 0) ? 1 : 0);
               end
               for (int j = 0; j < 150; j++) begin
                  repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                  drive(1, $urandom_range(0, 7), $urandom, $urandom, ($urandom_range(0, 15) == 0) ? 1 : 0);
               end
            join
            done = 1;
         end
         begin
            while (!done) begin
               rdy = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
            rdy = 1'b1;
         end
      join
      wait_idle();
      chk(bus.op_count == 255, "op_count_sat", bus.op_count, 255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
